spec_vram_arbiter: RTL and testbench

- Time-slotted arbiter sharing the single 16-bit video SRAM between the TV scanner's per-character fetch and CPU read/write requests.
- Runs on clkVid, which is twice the scanner pixel clock, so each 8-pixel character cell is one 16-cycle slot.
- Phases 0-3 of an active slot are reserved for the scanner fetch; the remaining phases serve the CPU through a req/ack handshake.
- In blanking slots the whole slot serves the CPU.

---
 rtl/spec_vram_arbiter.sv | 143 ++++++++++++++
 tb/tb_spec_vram_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_vram_arbiter.sv
// Time-slotted video SRAM arbiter: the scanner owns phases 0-3 of an active
// character slot, the CPU gets the rest of it and the whole of a blanking slot.
//
// state    | meaning
// ---------+----------------------------------------------------------
// C_IDLE   | bus free for CPU; samples cpu_req inside the CPU window
// C_SETUP  | address/data on the bus, OE or WE asserted
// C_STROBE | strobe held; read data captured / WE released on exit
// C_END    | cpu_ack high for one cycle, bus strobes inactive
module spec_vram_arbiter #(
  parameter int AW             = 14,
  parameter int DW             = 16,
  parameter int CPU_LAST_START = 12
) (
  input  logic          clkVid,
  input  logic          rst_n,
  input  logic          vid_strobe,
  input  logic          vid_active,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_oe_n,
  output logic          mem_we_n
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_SETUP  = 2'd1;
  localparam logic [1:0] C_STROBE = 2'd2;
  localparam logic [1:0] C_END    = 2'd3;

  localparam logic [3:0] LAST_PH  = 4'(CPU_LAST_START);
  localparam logic [3:0] VID_LAST = 4'd3;

  logic [3:0] phase_q;
  logic [3:0] phase_eff;
  logic       active_slot;
  logic [1:0] cstate;
  logic [1:0] cstate_nxt;
  logic       cpu_we_q;

  logic       cpu_win;
  logic       cpu_start;
  logic       resync_abort;
  logic       strobe_exit;
  logic       vid_fetch_start;
  logic       vid_fetch_end;

  // A strobe re-aligns the slot: the current cycle is phase 0 regardless.
  assign phase_eff = vid_strobe ? 4'd0 : phase_q;

  assign cpu_win = active_slot ? ((phase_eff > VID_LAST) && (phase_eff <= LAST_PH))
                               : (phase_eff <= LAST_PH);

  assign cpu_start       = (cstate == C_IDLE) && cpu_req && cpu_win;
  assign resync_abort    = vid_strobe && ((cstate == C_SETUP) || (cstate == C_STROBE));
  assign strobe_exit     = (cstate == C_STROBE) && !resync_abort;
  assign vid_fetch_start = active_slot && (phase_eff == 4'd0);
  assign vid_fetch_end   = active_slot && (phase_eff == VID_LAST);

  assign cpu_ack = (cstate == C_END);

  always_ff @(posedge clkVid or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 4'd0;
      active_slot <= 1'b0;
    end else begin
      phase_q <= phase_eff + 4'd1;
      if (phase_eff == 4'd15)
        active_slot <= vid_active;
    end
  end

  always_comb begin
    cstate_nxt = cstate;
    case (cstate)
      C_IDLE:   if (cpu_start) cstate_nxt = C_SETUP;
      C_SETUP:  cstate_nxt = resync_abort ? C_IDLE : C_STROBE;
      C_STROBE: cstate_nxt = resync_abort ? C_IDLE : C_END;
      C_END:    cstate_nxt = C_IDLE;
      default:  cstate_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clkVid or negedge rst_n) begin
    if (!rst_n) begin
      cstate   <= C_IDLE;
      cpu_we_q <= 1'b0;
    end else begin
      cstate <= cstate_nxt;
      if (cpu_start)
        cpu_we_q <= cpu_we;
    end
  end

  // The video fetch is applied last so that, on a resync, its OE assertion
  // wins over the CPU release of the bus in the same edge.
  always_ff @(posedge clkVid or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
    end else begin
      if (cpu_start) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_oe_n  <= cpu_we;
        mem_we_n  <= ~cpu_we;
      end else if (resync_abort || strobe_exit) begin
        mem_oe_n <= 1'b1;
        mem_we_n <= 1'b1;
      end

      if (vid_fetch_start) begin
        mem_addr <= vid_addr;
        mem_oe_n <= 1'b0;
      end else if (vid_fetch_end) begin
        mem_oe_n <= 1'b1;
      end
    end
  end

  always_ff @(posedge clkVid or negedge rst_n) begin
    if (!rst_n) begin
      vdata     <= '0;
      cpu_rdata <= '0;
    end else begin
      if (vid_fetch_end)
        vdata <= mem_rdata;
      if (strobe_exit && !cpu_we_q)
        cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_spec_vram_arbiter.sv
// Bench for spec_vram_arbiter: behavioural SRAM, directed slot scenarios and
// a scoreboard of expected CPU completions (phase of ack, read data).
module tb_spec_vram_arbiter;

  logic        clkVid;
  logic        rst_n;
  logic        vid_strobe;
  logic        vid_active;
  logic [13:0] vid_addr;
  logic [15:0] vdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_oe_n;
  logic        mem_we_n;

  typedef struct {
    logic        we;
    logic [15:0] data;
    int          ph;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          n_vec = 0;
  int          n_mis = 0;
  int          ph_m  = 0;
  logic [15:0] sram [0:16383];

  spec_vram_arbiter #(.AW(14), .DW(16), .CPU_LAST_START(12)) dut (
    .clkVid    (clkVid),
    .rst_n     (rst_n),
    .vid_strobe(vid_strobe),
    .vid_active(vid_active),
    .vid_addr  (vid_addr),
    .vdata     (vdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n)
  );

  initial clkVid = 1'b0;
  always #5 clkVid = ~clkVid;

  assign mem_rdata = sram[mem_addr];
  always @(posedge clkVid) if (mem_we_n == 1'b0) sram[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (phase %0d, t=%0t)", tag, obs, exp, ph_m, $time);
    end
  endtask

  // ph_m is the phase of the cycle following the edge just passed
  task automatic cyc();
    @(posedge clkVid); #1;
    ph_m = (ph_m + 1) % 16;
    vid_strobe = (ph_m == 0);
  endtask

  task automatic cyc_strobe();
    @(posedge clkVid); #1;
    ph_m = 0;
    vid_strobe = 1'b1;
  endtask

  task automatic run_to(input int p);
    int n;
    n = 0;
    cyc();
    while (ph_m != p && n < 32) begin
      cyc();
      n++;
    end
  endtask

  task automatic ph_checks(input int mode);
    if (mode == 1) begin
      if (ph_m == 5) begin
        chk("wr_addr", 32'(mem_addr), 32'h1234);
        chk("wr_data", 32'(mem_wdata), 32'hBEEF);
      end
      if (ph_m == 5 || ph_m == 6) chk("wr_we_low", 32'(mem_we_n), 0);
      if (ph_m == 7) chk("wr_we_rel", 32'(mem_we_n), 1);
    end else if (mode == 2) begin
      if (ph_m == 14 || ph_m == 15 || ph_m == 0) begin
        chk("blk_oe_idle", 32'(mem_oe_n), 1);
        chk("blk_we_idle", 32'(mem_we_n), 1);
      end
      if (ph_m >= 1 && ph_m <= 3) begin
        chk("blk_vid_addr", 32'(mem_addr), 32'h0ABC);
        chk("blk_vid_oe", 32'(mem_oe_n), 0);
      end
      if (ph_m == 4) chk("blk_vdata", 32'(vdata), 32'h05A5);
      if (ph_m == 5 || ph_m == 6) begin
        chk("blk_rd_addr", 32'(mem_addr), 32'h0010);
        chk("blk_rd_oe", 32'(mem_oe_n), 0);
      end
    end
  endtask

  task automatic wait_ack(input int mode);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 48) begin
      cyc();
      ph_checks(mode);
      got = (cpu_ack === 1'b1);
      n++;
    end
    if (!got) chk("ack_timeout", 32'(cpu_ack), 1);
  endtask

  always @(negedge clkVid) begin
    if (rst_n === 1'b1) begin
      chk("oe_we_excl", 32'(mem_oe_n | mem_we_n), 1);
      if (cpu_ack === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("spurious_ack", 32'(cpu_ack), 0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("ack_phase", 32'(ph_m), 32'(sb_e.ph));
          if (!sb_e.we) chk("rd_data", 32'(cpu_rdata), 32'(sb_e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = 16'h0000;
    sram[14'h0ABC] = 16'h05A5;
    sram[14'h0010] = 16'h00C3;

    rst_n = 1'b0;
    vid_strobe = 0; vid_active = 0; vid_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;

    // reset with random inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge clkVid); #1;
      vid_strobe = 1'($urandom);
      vid_active = 1'($urandom);
      vid_addr   = 14'($urandom);
      cpu_req    = 1'($urandom);
      cpu_we     = 1'($urandom);
      cpu_addr   = 14'($urandom);
      cpu_wdata  = 16'($urandom);
    end
    chk("rst_vdata", 32'(vdata), 0);
    chk("rst_ack", 32'(cpu_ack), 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_maddr", 32'(mem_addr), 0);
    chk("rst_mwdata", 32'(mem_wdata), 0);
    chk("rst_oe", 32'(mem_oe_n), 1);
    chk("rst_we", 32'(mem_we_n), 1);

    vid_active = 0; vid_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ph_m = 0;
    vid_strobe = 1'b1;
    rst_n = 1'b1;

    // blanking only: no fetch, OE idle
    for (int i = 0; i < 48; i++) begin
      cyc();
      chk("blank_oe", 32'(mem_oe_n), 1);
      chk("blank_vdata", 32'(vdata), 0);
    end

    // video fetch of 0x0ABC
    vid_active = 1'b1;
    vid_addr   = 14'h0ABC;
    run_to(15);
    run_to(1);
    chk("vid_addr", 32'(mem_addr), 32'h0ABC);
    chk("vid_oe_p1", 32'(mem_oe_n), 0);
    cyc();
    chk("vid_oe_p2", 32'(mem_oe_n), 0);
    cyc();
    chk("vid_oe_p3", 32'(mem_oe_n), 0);
    chk("vid_vdata_early", 32'(vdata), 0);
    cyc();
    chk("vid_oe_p4", 32'(mem_oe_n), 1);
    chk("vid_vdata", 32'(vdata), 32'h05A5);

    // CPU write requested during the video phases
    run_to(1);
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h1234; cpu_wdata = 16'hBEEF;
    sb_q.push_back('{we: 1'b1, data: 16'hBEEF, ph: 7});
    wait_ack(1);
    cyc();
    cpu_req = 0;
    vid_addr = 14'h1234;
    run_to(4);
    chk("vid_after_wr", 32'(vdata), 32'hBEEF);

    // CPU read arriving after the last start phase
    vid_addr = 14'h0ABC;
    run_to(13);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010; cpu_wdata = 16'h0000;
    sb_q.push_back('{we: 1'b0, data: 16'h00C3, ph: 7});
    wait_ack(2);
    cyc();
    cpu_req = 0;
    chk("rdata_hold", 32'(cpu_rdata), 32'h00C3);

    // blanking slots, back-to-back alternating write/read
    run_to(15);
    vid_active = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cpu_req   = 1;
      cpu_we    = (k % 2 == 0);
      cpu_addr  = 14'h0100 + 14'(k / 2);
      cpu_wdata = 16'h1000 + 16'(k / 2);
      sb_q.push_back('{we: cpu_we, data: 16'h1000 + 16'(k / 2), ph: (k % 4) * 4 + 3});
      wait_ack(0);
      cyc();
    end
    cpu_req = 0;

    // write aborted by a resync strobe, then retried
    vid_active = 1'b1;
    vid_addr   = 14'h2000;
    run_to(15);
    run_to(1);
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h2000; cpu_wdata = 16'h5A5A;
    sb_q.push_back('{we: 1'b1, data: 16'h5A5A, ph: 7});
    run_to(5);
    chk("abort_we_setup", 32'(mem_we_n), 0);
    cyc_strobe();
    chk("abort_we_strobe", 32'(mem_we_n), 0);
    cyc();
    chk("abort_we_rel", 32'(mem_we_n), 1);
    chk("abort_no_ack", 32'(cpu_ack), 0);
    wait_ack(0);
    cyc();
    cpu_req = 0;
    repeat (20) cyc();
    run_to(4);
    chk("retry_vid", 32'(vdata), 32'h5A5A);
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
